// File: rtl/fpnew_issue_rob.sv
// ============================================================================
// fpnew_issue_rob : tag-allocating issue stage and in-order reorder buffer
// Revision        : 1.0
// ============================================================================
`default_nettype none

module fpnew_issue_rob #(
   parameter int FLEN      = 16,
   parameter int TAG_WIDTH = 2,
   parameter int CTRL_W    = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   cmd_valid_i,
   output logic                   cmd_ready_o,
   input  logic [3*FLEN-1:0]      cmd_operands_i,
   input  logic [CTRL_W-1:0]      cmd_ctrl_i,
   output logic                   fpu_valid_o,
   input  logic                   fpu_ready_i,
   output logic [3*FLEN-1:0]      fpu_operands_o,
   output logic [CTRL_W-1:0]      fpu_ctrl_o,
   output logic [TAG_WIDTH-1:0]   fpu_tag_o,
   input  logic                   fpu_valid_i,
   output logic                   fpu_ready_o,
   input  logic [FLEN-1:0]        fpu_result_i,
   input  logic [4:0]             fpu_status_i,
   input  logic [TAG_WIDTH-1:0]   fpu_tag_i,
   output logic                   resp_valid_o,
   input  logic                   resp_ready_i,
   output logic [FLEN-1:0]        resp_result_o,
   output logic [4:0]             resp_status_o,
   output logic                   busy_o
);

   localparam int                 c_depth = 2**TAG_WIDTH;
   localparam logic [TAG_WIDTH:0] c_full  = (TAG_WIDTH+1)'(c_depth);

   logic [TAG_WIDTH-1:0] r_alloc_ptr;
   logic [TAG_WIDTH-1:0] r_retire_ptr;
   logic [TAG_WIDTH:0]   r_count;
   logic [c_depth-1:0]   r_done;
   logic [FLEN-1:0]      r_res [c_depth];
   logic [4:0]           r_sts [c_depth];

   logic                 w_space;
   logic                 w_issue;
   logic                 w_retire;
   logic [TAG_WIDTH-1:0] w_tag_off;
   logic                 w_cap_ok;
   logic                 w_capture;

   // Reset gates the handshake outputs so they read idle while rst_i is held.
   assign w_space        = (r_count != c_full) & ~rst_i;
   assign fpu_valid_o    = cmd_valid_i & w_space;
   assign cmd_ready_o    = fpu_ready_i & w_space;
   assign fpu_operands_o = cmd_operands_i;
   assign fpu_ctrl_o     = cmd_ctrl_i;
   assign fpu_tag_o      = r_alloc_ptr;
   assign fpu_ready_o    = 1'b1;

   assign w_issue  = fpu_valid_o & fpu_ready_i;
   assign w_retire = resp_valid_o & resp_ready_i;

   // A tag is in flight when its distance from the retire pointer is below count.
   assign w_tag_off = fpu_tag_i - r_retire_ptr;
   assign w_cap_ok  = ~r_done[fpu_tag_i] & ({1'b0, w_tag_off} < r_count);
   assign w_capture = fpu_valid_i & w_cap_ok;

   assign resp_valid_o  = r_done[r_retire_ptr];
   assign resp_result_o = r_res[r_retire_ptr];
   assign resp_status_o = r_sts[r_retire_ptr];
   assign busy_o        = (r_count != '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_alloc_ptr  <= '0;
         r_retire_ptr <= '0;
         r_count      <= '0;
         r_done       <= '0;
      end else begin
         if (w_issue) begin
            r_alloc_ptr <= r_alloc_ptr + 1'b1;
         end
         if (w_retire) begin
            r_retire_ptr         <= r_retire_ptr + 1'b1;
            r_done[r_retire_ptr] <= 1'b0;
         end
         if (w_capture) begin
            r_done[fpu_tag_i] <= 1'b1;
         end
         if (w_issue && !w_retire) begin
            r_count <= r_count + 1'b1;
         end else if (!w_issue && w_retire) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_capture) begin
         r_res[fpu_tag_i] <= fpu_result_i;
         r_sts[fpu_tag_i] <= fpu_status_i;
      end
   end

   // Results for tags that are already done or were never issued are dropped.
   a_capture_legal : assert property (@(posedge clk_i) disable iff (rst_i)
                                      fpu_valid_i |-> w_cap_ok);

endmodule

`default_nettype wire

// File: tb/tb_fpnew_issue_rob.sv
// ============================================================================
// tb_fpnew_issue_rob : vector table, directed corner sequences, random vs model
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_fpnew_issue_rob;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [47:0] cmd_operands_i;
   logic [15:0] cmd_ctrl_i;
   logic        fpu_valid_o;
   logic        fpu_ready_i;
   logic [47:0] fpu_operands_o;
   logic [15:0] fpu_ctrl_o;
   logic [1:0]  fpu_tag_o;
   logic        fpu_valid_i;
   logic        fpu_ready_o;
   logic [15:0] fpu_result_i;
   logic [4:0]  fpu_status_i;
   logic [1:0]  fpu_tag_i;
   logic        resp_valid_o;
   logic        resp_ready_i;
   logic [15:0] resp_result_o;
   logic [4:0]  resp_status_o;
   logic        busy_o;

   int n_err = 0;
   int n_chk = 0;

   fpnew_issue_rob #(.FLEN(16), .TAG_WIDTH(2), .CTRL_W(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_operands_i(cmd_operands_i), .cmd_ctrl_i(cmd_ctrl_i),
      .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i),
      .fpu_operands_o(fpu_operands_o), .fpu_ctrl_o(fpu_ctrl_o),
      .fpu_tag_o(fpu_tag_o), .fpu_valid_i(fpu_valid_i),
      .fpu_ready_o(fpu_ready_o), .fpu_result_i(fpu_result_i),
      .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
      .resp_result_o(resp_result_o), .resp_status_o(resp_status_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rst, cv, fr, fvi;
      logic [1:0]  ti;
      logic [15:0] ri;
      logic        rr;
      logic        e_cr, e_fv;
      logic [1:0]  e_tag;
      logic        e_rv;
      logic [15:0] e_res;
      logic        e_busy;
   } vec_t;

   typedef struct {
      logic [1:0]  tag;
      bit          done;
      logic [15:0] res;
      logic [4:0]  sts;
   } ent_t;

   vec_t tbl[$];

   function automatic void add(input logic rst, cv, fr, fvi, input logic [1:0] ti,
                               input logic [15:0] ri, input logic rr, e_cr, e_fv,
                               input logic [1:0] e_tag, input logic e_rv,
                               input logic [15:0] e_res, input logic e_busy);
      vec_t v;
      v.rst = rst; v.cv = cv; v.fr = fr; v.fvi = fvi; v.ti = ti; v.ri = ri; v.rr = rr;
      v.e_cr = e_cr; v.e_fv = e_fv; v.e_tag = e_tag; v.e_rv = e_rv;
      v.e_res = e_res; v.e_busy = e_busy;
      tbl.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic set_in(input logic cv, fr, fvi, input logic [1:0] ti,
                         input logic [15:0] ri, input logic rr);
      cmd_valid_i  = cv;
      fpu_ready_i  = fr;
      fpu_valid_i  = fvi;
      fpu_tag_i    = ti;
      fpu_result_i = ri;
      fpu_status_i = 5'd0;
      resp_ready_i = rr;
   endtask

   // Every cycle starts at posedge+1; checks happen at posedge+2.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 1, 0, 0, 0, 0);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   task automatic issue_n(input int n);
      for (int i = 0; i < n; i++) begin
         set_in(1, 1, 0, 0, 0, 0);
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      ent_t        mq[$];
      logic [1:0]  pend[$];
      int          nalloc;
      int unsigned pidx;
      logic        cv, fr, fvi, rr, e_rv, e_sp;
      logic [1:0]  ti;
      logic [15:0] ri;
      logic [4:0]  si;

      rst_i          = 1'b1;
      cmd_operands_i = {16'h0000, 16'h4000, 16'h3F80};
      cmd_ctrl_i     = 16'h0000;
      set_in(0, 1, 0, 0, 0, 0);
      #1;
      chk("reset_fpu_valid", 64'(fpu_valid_o), 64'd0);
      chk("reset_cmd_ready", 64'(cmd_ready_o), 64'd0);
      chk("reset_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_fpu_ready", 64'(fpu_ready_o), 64'd1);
      chk("reset_fpu_tag", 64'(fpu_tag_o), 64'd0);
      tick();
      rst_i = 1'b0;

      // single op, reset row, then out-of-order return of tags 2,0,3,1
      add(0,1,1,0,0,16'h0000,1, 1,1,0,0,16'h0000,0);
      add(0,0,1,0,0,16'h0000,1, 1,0,1,0,16'h0000,1);
      add(0,0,1,0,0,16'h0000,1, 1,0,1,0,16'h0000,1);
      add(0,0,1,1,0,16'h4040,1, 1,0,1,0,16'h0000,1);
      add(0,0,1,0,0,16'h0000,1, 1,0,1,1,16'h4040,1);
      add(0,0,1,0,0,16'h0000,1, 1,0,1,0,16'h0000,0);
      add(1,1,1,0,0,16'h0000,1, 0,0,0,0,16'h0000,0);
      add(0,1,1,0,0,16'h0000,0, 1,1,0,0,16'h0000,0);
      add(0,1,1,0,0,16'h0000,0, 1,1,1,0,16'h0000,1);
      add(0,1,1,0,0,16'h0000,0, 1,1,2,0,16'h0000,1);
      add(0,1,1,0,0,16'h0000,0, 1,1,3,0,16'h0000,1);
      add(0,1,1,1,2,16'h000A,0, 0,0,0,0,16'h0000,1);
      add(0,0,1,1,0,16'h000B,0, 0,0,0,0,16'h0000,1);
      add(0,0,1,1,3,16'h000C,0, 0,0,0,1,16'h000B,1);
      add(0,0,1,1,1,16'h000D,1, 0,0,0,1,16'h000B,1);
      add(0,0,1,0,0,16'h0000,1, 1,0,0,1,16'h000D,1);
      add(0,0,1,0,0,16'h0000,1, 1,0,0,1,16'h000A,1);
      add(0,0,1,0,0,16'h0000,1, 1,0,0,1,16'h000C,1);
      add(0,0,1,0,0,16'h0000,0, 1,0,0,0,16'h0000,0);

      foreach (tbl[i]) begin
         rst_i = tbl[i].rst;
         set_in(tbl[i].cv, tbl[i].fr, tbl[i].fvi, tbl[i].ti, tbl[i].ri, tbl[i].rr);
         #1;
         chk($sformatf("vec%0d_cmd_ready", i), 64'(cmd_ready_o), 64'(tbl[i].e_cr));
         chk($sformatf("vec%0d_fpu_valid", i), 64'(fpu_valid_o), 64'(tbl[i].e_fv));
         chk($sformatf("vec%0d_fpu_tag", i), 64'(fpu_tag_o), 64'(tbl[i].e_tag));
         chk($sformatf("vec%0d_resp_valid", i), 64'(resp_valid_o), 64'(tbl[i].e_rv));
         chk($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
         if (tbl[i].e_rv)
            chk($sformatf("vec%0d_resp_result", i), 64'(resp_result_o), 64'(tbl[i].e_res));
         tick();
      end
      rst_i = 1'b0;

      // fill, full stall, response backpressure, then drain
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(1, 1, 0, 0, 0, 0);
         #1;
         chk("fill_tag", 64'(fpu_tag_o), 64'(i));
         chk("fill_fpu_valid", 64'(fpu_valid_o), 64'd1);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         set_in(1, 1, 1, 2'(i), 16'h0100 + 16'(i), 0);
         #1;
         chk("full_cmd_ready", 64'(cmd_ready_o), 64'd0);
         chk("full_fpu_valid", 64'(fpu_valid_o), 64'd0);
         tick();
      end
      for (int i = 0; i < 10; i++) begin
         set_in(1, 1, 0, 0, 0, 0);
         #1;
         chk("bp_resp_valid", 64'(resp_valid_o), 64'd1);
         chk("bp_resp_result", 64'(resp_result_o), 64'h0100);
         chk("bp_cmd_ready", 64'(cmd_ready_o), 64'd0);
         tick();
      end
      set_in(1, 1, 0, 0, 0, 1);
      #1;
      chk("drain0_result", 64'(resp_result_o), 64'h0100);
      chk("drain0_cmd_ready", 64'(cmd_ready_o), 64'd0);
      tick();
      set_in(1, 1, 0, 0, 0, 1);
      #1;
      chk("drain1_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("drain1_fpu_tag", 64'(fpu_tag_o), 64'd0);
      chk("drain1_result", 64'(resp_result_o), 64'h0101);
      tick();
      for (int i = 2; i < 4; i++) begin
         set_in(0, 1, 0, 0, 0, 1);
         #1;
         chk("drain_resp_valid", 64'(resp_valid_o), 64'd1);
         chk("drain_result", 64'(resp_result_o), 64'h0100 + 64'(i));
         tick();
      end
      set_in(0, 1, 0, 0, 0, 1);
      #1;
      chk("drain_end_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("drain_end_busy", 64'(busy_o), 64'd1);

      // wrap with same-cycle issue and retire at count 3
      do_reset();
      issue_n(3);
      set_in(0, 1, 1, 0, 16'h0055, 0);
      tick();
      set_in(1, 1, 0, 0, 0, 1);
      #1;
      chk("wrap_tag3", 64'(fpu_tag_o), 64'd3);
      chk("wrap_issue", 64'(fpu_valid_o), 64'd1);
      chk("wrap_retire", 64'(resp_valid_o), 64'd1);
      tick();
      set_in(1, 1, 0, 0, 0, 0);
      #1;
      chk("wrap_tag0", 64'(fpu_tag_o), 64'd0);
      chk("wrap_space", 64'(cmd_ready_o), 64'd1);
      tick();
      set_in(1, 1, 0, 0, 0, 0);
      #1;
      chk("wrap_full_after", 64'(cmd_ready_o), 64'd0);

      // reset while two are in flight and one is done
      do_reset();
      issue_n(2);
      set_in(0, 1, 1, 0, 16'h0077, 0);
      tick();
      set_in(1, 1, 0, 0, 0, 1);
      #1;
      chk("midrst_pre_resp_valid", 64'(resp_valid_o), 64'd1);
      rst_i = 1'b1;
      #1;
      chk("midrst_fpu_valid", 64'(fpu_valid_o), 64'd0);
      chk("midrst_cmd_ready", 64'(cmd_ready_o), 64'd0);
      chk("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_fpu_tag", 64'(fpu_tag_o), 64'd0);
      tick();
      rst_i = 1'b0;
      set_in(1, 1, 0, 0, 0, 0);
      #1;
      chk("postrst_tag", 64'(fpu_tag_o), 64'd0);
      chk("postrst_fpu_valid", 64'(fpu_valid_o), 64'd1);
      tick();
      set_in(0, 1, 0, 0, 0, 1);
      #1;
      chk("postrst_busy", 64'(busy_o), 64'd1);
      chk("postrst_resp_valid", 64'(resp_valid_o), 64'd0);

      // random traffic against an issue-order queue model
      do_reset();
      nalloc = 0;
      for (int c = 0; c < 3000; c++) begin
         cv  = ($urandom_range(0, 3) != 0);
         fr  = ($urandom_range(0, 3) != 0);
         rr  = ($urandom_range(0, 2) == 0);
         fvi = 1'b0;
         ti  = 2'd0;
         pidx = 0;
         ri  = 16'($urandom);
         si  = 5'($urandom);
         if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
            fvi  = 1'b1;
            pidx = $urandom_range(0, pend.size() - 1);
            ti   = pend[pidx];
         end
         set_in(cv, fr, fvi, ti, ri, rr);
         fpu_status_i   = si;
         cmd_operands_i = {16'($urandom), 32'($urandom)};
         cmd_ctrl_i     = 16'($urandom);
         #1;
         e_sp = (mq.size() < 4);
         e_rv = (mq.size() > 0) && mq[0].done;
         chk("rnd_cmd_ready", 64'(cmd_ready_o), 64'(fr & e_sp));
         chk("rnd_fpu_valid", 64'(fpu_valid_o), 64'(cv & e_sp));
         chk("rnd_fpu_tag", 64'(fpu_tag_o), 64'(nalloc % 4));
         chk("rnd_resp_valid", 64'(resp_valid_o), 64'(e_rv));
         chk("rnd_busy", 64'(busy_o), 64'(mq.size() != 0));
         chk("rnd_operands", 64'(fpu_operands_o), 64'(cmd_operands_i));
         chk("rnd_ctrl", 64'(fpu_ctrl_o), 64'(cmd_ctrl_i));
         chk("rnd_fpu_ready", 64'(fpu_ready_o), 64'd1);
         if (e_rv) begin
            chk("rnd_resp_result", 64'(resp_result_o), 64'(mq[0].res));
            chk("rnd_resp_status", 64'(resp_status_o), 64'(mq[0].sts));
         end
         if (e_rv && rr) void'(mq.pop_front());
         if (fvi) begin
            foreach (mq[k]) begin
               if (mq[k].tag == ti) begin
                  mq[k].done = 1'b1;
                  mq[k].res  = ri;
                  mq[k].sts  = si;
               end
            end
            pend.delete(pidx);
         end
         if (cv && fr && e_sp) begin
            ent_t e;
            e.tag  = 2'(nalloc % 4);
            e.done = 1'b0;
            e.res  = 16'h0;
            e.sts  = 5'h0;
            mq.push_back(e);
            pend.push_back(e.tag);
            nalloc++;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
